// File: rtl/input_port_reg.sv
// Input port register: captures a nibble over a 4-phase InStrobe/InAck handshake and presents it on IB.
// Optional macro INPORT_FIFO2_EN selects a 2-entry circular buffer instead of a single holding register.
module input_port_reg #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              MainClock,
  input  logic              MainReset,
  input  logic [DATA_W-1:0] InData,
  input  logic              InStrobe,
  output logic              InAck,
  input  logic              ReadIn,
  output logic [DATA_W-1:0] IB,
  output logic              IBEn,
  output logic              InReady,
  output logic              Overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  state_t                 w_nextState;
  logic                   r_inAck;
  logic                   w_ackNext;
  logic                   r_inReady;
  logic                   r_overrun;
  logic                   w_sStrobe;
  logic                   w_push;
  logic                   w_reject;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_notEmptyNext;
  logic [DATA_W-1:0]      w_head;

  assign w_sStrobe = r_sync[SYNC_STAGES-1];
  assign w_pop     = ReadIn & r_inReady;

  assign InAck   = r_inAck;
  assign InReady = r_inReady;
  assign Overrun = r_overrun;
  assign IBEn    = w_pop;
  assign IB      = w_pop ? w_head : '0;

  always_ff @(posedge MainClock) begin
    if (!MainReset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], InStrobe};
    end
  end

  // One capture per strobe high phase: after a push we wait for sStrobe to fall before re-arming.
  always_comb begin
    w_nextState = r_state;
    w_ackNext   = r_inAck;
    w_push      = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      IDLE: begin
        w_ackNext = 1'b0;
        if (w_sStrobe) begin
          if (!w_full) begin
            w_push      = 1'b1;
            w_nextState = ACK;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ACK: begin
        w_ackNext   = 1'b1;
        w_nextState = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!w_sStrobe) begin
          w_ackNext   = 1'b0;
          w_nextState = IDLE;
        end
      end
      default: begin
        w_ackNext   = 1'b0;
        w_nextState = IDLE;
      end
    endcase
  end

  // A pop clears Overrun even if the same edge rejects another strobe, so the
  // freed slot can be filled on the following idle edge.
  always_ff @(posedge MainClock) begin
    if (!MainReset) begin
      r_state   <= IDLE;
      r_inAck   <= 1'b0;
      r_inReady <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_inAck   <= w_ackNext;
      r_inReady <= w_notEmptyNext;
      if (w_pop && r_overrun) begin
        r_overrun <= 1'b0;
      end else if (w_reject) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef INPORT_FIFO2_EN
  logic [DATA_W-1:0] r_mem [2];
  logic              r_wrPtr;
  logic              r_rdPtr;
  logic [1:0]        r_count;
  logic [1:0]        w_countNext;

  assign w_full         = (r_count == 2'd2);
  assign w_head         = r_mem[r_rdPtr];
  assign w_notEmptyNext = (w_countNext != 2'd0);

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 2'd1;
      2'b01:   w_countNext = r_count - 2'd1;
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge MainClock) begin
    if (!MainReset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wrPtr  <= 1'b0;
      r_rdPtr  <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= InData;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= w_countNext;
    end
  end
`else
  logic [DATA_W-1:0] r_hold;
  logic              r_full;

  assign w_full         = r_full;
  assign w_head         = r_hold;
  assign w_notEmptyNext = w_push | (r_full & ~w_pop);

  always_ff @(posedge MainClock) begin
    if (!MainReset) begin
      r_hold <= '0;
      r_full <= 1'b0;
    end else if (w_push) begin
      r_hold <= InData;
      r_full <= 1'b1;
    end else if (w_pop) begin
      r_full <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_input_port_reg.sv
// Directed self-checking bench for input_port_reg; the FIFO2 section runs when INPORT_FIFO2_EN is defined.
module tb_input_port_reg;

  logic       MainClock;
  logic       MainReset;
  logic [3:0] InData;
  logic       InStrobe;
  logic       InAck;
  logic       ReadIn;
  logic [3:0] IB;
  logic       IBEn;
  logic       InReady;
  logic       Overrun;

  int checkCount;
  int errorCount;

  input_port_reg #(.DATA_W(4), .SYNC_STAGES(2)) dut (
    .MainClock(MainClock),
    .MainReset(MainReset),
    .InData(InData),
    .InStrobe(InStrobe),
    .InAck(InAck),
    .ReadIn(ReadIn),
    .IB(IB),
    .IBEn(IBEn),
    .InReady(InReady),
    .Overrun(Overrun)
  );

  initial MainClock = 1'b0;
  always #5 MainClock = ~MainClock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge MainClock);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Full handshake: raise strobe, expect capture on edge 3 and ack on edge 4, then release.
  task automatic applyStimulus(input logic [3:0] data, input string tag);
    InData   = data;
    InStrobe = 1'b1;
    tick(3);
    checkOutput({tag, "_ready"}, {7'd0, InReady}, 8'd1);
    tick(1);
    checkOutput({tag, "_ack"}, {7'd0, InAck}, 8'd1);
    InStrobe = 1'b0;
    tick(3);
    checkOutput({tag, "_ackLow"}, {7'd0, InAck}, 8'd0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    MainReset  = 1'b0;
    InData     = 4'h0;
    InStrobe   = 1'b1;
    ReadIn     = 1'b1;
    tick(2);
    checkOutput("rst_InAck", {7'd0, InAck}, 8'd0);
    checkOutput("rst_InReady", {7'd0, InReady}, 8'd0);
    checkOutput("rst_IBEn", {7'd0, IBEn}, 8'd0);
    checkOutput("rst_IB", {4'd0, IB}, 8'd0);
    checkOutput("rst_Overrun", {7'd0, Overrun}, 8'd0);

    MainReset = 1'b1;
    InStrobe  = 1'b0;
    ReadIn    = 1'b0;
    tick(1);

    // Single transfer with exact edge timing
    InData   = 4'hA;
    InStrobe = 1'b1;
    tick(2);
    checkOutput("single_readyEdge2", {7'd0, InReady}, 8'd0);
    tick(1);
    checkOutput("single_readyEdge3", {7'd0, InReady}, 8'd1);
    checkOutput("single_ackEdge3", {7'd0, InAck}, 8'd0);
    tick(1);
    checkOutput("single_ackEdge4", {7'd0, InAck}, 8'd1);
    InStrobe = 1'b0;
    tick(2);
    checkOutput("single_ackHeld", {7'd0, InAck}, 8'd1);
    tick(1);
    checkOutput("single_ackDrop", {7'd0, InAck}, 8'd0);
    ReadIn = 1'b1;
    #1;
    checkOutput("single_IBEn", {7'd0, IBEn}, 8'd1);
    checkOutput("single_IB", {4'd0, IB}, 8'hA);
    tick(1);
    ReadIn = 1'b0;
    checkOutput("single_readyAfter", {7'd0, InReady}, 8'd0);
    checkOutput("single_IBAfter", {4'd0, IB}, 8'd0);

    // Read with nothing buffered
    ReadIn = 1'b1;
    #1;
    checkOutput("empty_IB", {4'd0, IB}, 8'd0);
    checkOutput("empty_IBEn", {7'd0, IBEn}, 8'd0);
    tick(1);
    checkOutput("empty_InReady", {7'd0, InReady}, 8'd0);
    checkOutput("empty_Overrun", {7'd0, Overrun}, 8'd0);
    ReadIn = 1'b0;

`ifdef INPORT_FIFO2_EN
    applyStimulus(4'h1, "fifo_w1");
    applyStimulus(4'h2, "fifo_w2");
    checkOutput("fifo_InReady", {7'd0, InReady}, 8'd1);
    checkOutput("fifo_Overrun", {7'd0, Overrun}, 8'd0);
    ReadIn = 1'b1;
    #1;
    checkOutput("fifo_IB1", {4'd0, IB}, 8'h1);
    tick(1);
    checkOutput("fifo_IB2", {4'd0, IB}, 8'h2);
    checkOutput("fifo_IBEn2", {7'd0, IBEn}, 8'd1);
    tick(1);
    ReadIn = 1'b0;
    checkOutput("fifo_readyEnd", {7'd0, InReady}, 8'd0);
`else
    applyStimulus(4'h3, "full_w3");
    InData   = 4'h5;
    InStrobe = 1'b1;
    tick(3);
    checkOutput("full_Overrun", {7'd0, Overrun}, 8'd1);
    checkOutput("full_ackLow", {7'd0, InAck}, 8'd0);
    tick(1);
    checkOutput("full_ackStillLow", {7'd0, InAck}, 8'd0);
    ReadIn = 1'b1;
    #1;
    checkOutput("full_IB3", {4'd0, IB}, 8'h3);
    tick(1);
    ReadIn = 1'b0;
    checkOutput("full_OverrunClr", {7'd0, Overrun}, 8'd0);
    checkOutput("full_readyEmpty", {7'd0, InReady}, 8'd0);
    tick(1);
    checkOutput("full_recapture", {7'd0, InReady}, 8'd1);
    checkOutput("full_recapAckLow", {7'd0, InAck}, 8'd0);
    tick(1);
    checkOutput("full_recapAck", {7'd0, InAck}, 8'd1);
    InStrobe = 1'b0;
    tick(3);
    ReadIn = 1'b1;
    #1;
    checkOutput("full_IB5", {4'd0, IB}, 8'h5);
    tick(1);
    ReadIn = 1'b0;
`endif

    // Reset while the FSM sits in ACK
    InData   = 4'h7;
    InStrobe = 1'b1;
    tick(3);
    checkOutput("mid_preReady", {7'd0, InReady}, 8'd1);
    MainReset = 1'b0;
    tick(1);
    checkOutput("mid_InAck", {7'd0, InAck}, 8'd0);
    checkOutput("mid_InReady", {7'd0, InReady}, 8'd0);
    MainReset = 1'b1;
    InData    = 4'h9;
    tick(3);
    checkOutput("mid_freshReady", {7'd0, InReady}, 8'd1);
    tick(1);
    checkOutput("mid_freshAck", {7'd0, InAck}, 8'd1);
    InStrobe = 1'b0;
    tick(3);
    ReadIn = 1'b1;
    #1;
    checkOutput("mid_IB9", {4'd0, IB}, 8'h9);
    tick(1);
    ReadIn = 1'b0;
    checkOutput("mid_readyEnd", {7'd0, InReady}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/input_port_reg.md
Name: input_port_reg

Overview:
- Input-side counterpart of the 4-bit output register: captures a nibble from an external producer and presents it on the internal bus IB for the datapath to read.
- External side uses a 4-phase InStrobe/InAck handshake, with InStrobe synchronised into the MainClock domain.
- Internal side reads with a one-cycle ReadIn pulse.
- Sits between the external input pins and the IB bus, alongside the output register.

Parameters:
- DATA_W, 4, width of captured data and of IB.
- SYNC_STAGES, 2, flip-flop stages on InStrobe (minimum 2).

Ports:
- MainClock  input  1  single system clock; all state updates on rising edge.
- MainReset  input  1  synchronous, active-low reset.
- InData  input  DATA_W  external data; stable while InStrobe high.
- InStrobe  input  1  external request, asynchronous to MainClock.
- InAck  output  1  handshake acknowledge to external producer.
- ReadIn  input  1  internal read request (one cycle = one pop).
- IB  output  DATA_W  internal bus data.
- IBEn  output  1  high when IB carries valid read data.
- InReady  output  1  buffer holds at least one unread word.
- Overrun  output  1  sticky: strobe rejected because buffer full.

Behaviour:
- Reset: all state cleared on the MainClock edge while MainReset=0.
  - Outputs after reset: InAck=0, InReady=0, Overrun=0, IBEn=0, IB=0.
  - Sync chain and buffer cleared; FSM returns to IDLE.
  - Reset mid-handshake aborts the handshake: InAck drops, captured data is lost.
- Sync: InStrobe passes through SYNC_STAGES flops; sStrobe is the last stage.
- Handshake FSM, states IDLE, ACK, WAIT_LOW:
  - IDLE: if sStrobe=1 and count<DEPTH, write InData to the tail, count+1, go to ACK. The write uses count sampled before the edge.
  - IDLE: if sStrobe=1 and count=DEPTH, set Overrun=1 and stay in IDLE (no capture). The producer is held off because InAck is not asserted.
  - ACK: InAck=1 (registered); go to WAIT_LOW.
  - WAIT_LOW: InAck stays 1 until sStrobe=0; then InAck=0 and go to IDLE.
  - A producer that keeps InStrobe high is captured exactly once per high phase.
- Capture latency: InStrobe rise to word written = SYNC_STAGES+1 edges; InAck high one edge later.
- Read path:
  - IBEn = ReadIn & InReady (combinational).
  - IB = head word when IBEn=1, else 0. IB never floats.
  - Pop at the edge where IBEn=1: count-1.
- ReadIn with the buffer empty: IB=0, IBEn=0, no state change, no error.
- Push and pop in the same cycle: both happen and count is unchanged. Push eligibility is still judged on the pre-edge count.
- InReady = (count != 0), registered.
- Overrun: cleared only by reset or by a ReadIn that pops while Overrun=1 (clears on that edge).
- DEPTH = 1 by default; see Optional Feature.
- Pointers (2-entry mode) are 1 bit each and wrap naturally.

Optional Feature:
- Macro: INPORT_FIFO2_EN.
- Defined: DEPTH=2, a 2-entry circular buffer with read/write pointers and a 2-bit count. Producer can deliver a second word before the datapath reads the first.
- Undefined: DEPTH=1, a single holding register with a full flag. A second strobe while full raises Overrun.
- IB/IBEn/handshake timing is identical in both modes.

Test Plan:
- Reset: MainReset=0 for 2 edges with InStrobe=1 and ReadIn=1 -> InAck=0, InReady=0, IBEn=0, IB=0, Overrun=0.
- Single transfer:
  - InData=4'hA, raise InStrobe -> InReady=1 at edge 3 and InAck=1 at edge 4.
  - Drop InStrobe -> InAck=0 within 3 edges.
  - ReadIn=1 for one cycle -> IB=4'hA, IBEn=1, then InReady=0.
- Empty read: ReadIn=1 with buffer empty -> IB=0, IBEn=0, count unchanged, Overrun=0.
- Full (DEPTH=1):
  - Capture 4'h3, then strobe 4'h5 without reading -> InAck stays 0, Overrun=1.
  - ReadIn -> IB=4'h3, Overrun=0.
  - Next idle edge captures 4'h5 and InAck rises.
- INPORT_FIFO2_EN: capture 4'h1 then 4'h2, no reads -> both acked, InReady=1. Two ReadIn pulses -> IB=4'h1 then 4'h2, then InReady=0.
- Mid-handshake reset: MainReset=0 while in ACK state -> next edge InAck=0, InReady=0. Holding InStrobe high after reset produces a fresh capture of the current InData.
